gpio_core_ctrl: RTL and testbench

Core-side GPIO controller placed directly downstream of PADRING. It consumes the pad-input bus (pdr_OUT) and test-mode bus (out_t) and produces the pad-output bus (pdr_IN) and test-mode return bus (in_t). It synchronises and debounces pad inputs, latches rising-edge events into sticky interrupt flags, and holds the core's output register. When test mode is active it switches to a registered loopback path.

---
 rtl/gpio_core_ctrl.sv | 106 ++++++++++
 tb/tb_gpio_core_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_core_ctrl.sv
// Core-side GPIO controller: pad input sync/debounce, sticky rising-edge flags,
// output register, and a registered test-mode loopback selected by a synced tm_en.
module gpio_core_ctrl #(
  parameter int unsigned DATA_WIDTH      = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pdr_out,
  output logic [DATA_WIDTH-1:0] pdr_in,
  input  logic [DATA_WIDTH-1:0] tm_in,
  output logic [DATA_WIDTH-1:0] tm_out,
  input  logic                  tm_en,
  input  logic                  core_wr_en,
  input  logic [DATA_WIDTH-1:0] core_wr_data,
  output logic [DATA_WIDTH-1:0] core_rd_data,
  input  logic [DATA_WIDTH-1:0] irq_clr,
  output logic [DATA_WIDTH-1:0] irq_flags,
  output logic                  edge_irq
);

  typedef enum logic {
    NORMAL = 1'b0,
    TEST   = 1'b1
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic [DATA_WIDTH-1:0] stable_q, stable_d;
  logic [DATA_WIDTH-1:0] flags_q, flags_d;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] tm_data_q, tm_loop_q;
  logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
  logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
  logic                  tm_s1_q;
  mode_e                 mode_q, mode_d;

  // Per-bit debounce; any sample matching the stable value restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A new rising update takes priority over a same-cycle clear.
  always_comb begin
    flags_d   = (flags_q & ~irq_clr) | (stable_d & ~stable_q);
    out_reg_d = core_wr_en ? core_wr_data : out_reg_q;
  end

  always_comb begin
    mode_d = tm_s1_q ? TEST : NORMAL;
    pdr_in = out_reg_q;
    tm_out = '0;
    if (mode_q == TEST) begin
      pdr_in = tm_data_q;
      tm_out = tm_loop_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      flags_q   <= '0;
      out_reg_q <= '0;
      tm_data_q <= '0;
      tm_loop_q <= '0;
      tm_s1_q   <= 1'b0;
      mode_q    <= NORMAL;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= pdr_out;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      flags_q   <= flags_d;
      out_reg_q <= out_reg_d;
      tm_data_q <= tm_in;
      tm_loop_q <= s2_q;
      tm_s1_q   <= tm_en;
      mode_q    <= mode_d;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign core_rd_data = stable_q;
  assign irq_flags    = flags_q;
  assign edge_irq     = |flags_q;

endmodule

// File: tb/tb_gpio_core_ctrl.sv
// Directed bench for gpio_core_ctrl with default parameters (15 bits, 4-cycle debounce).
module tb_gpio_core_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] pdr_out = '0;
  logic [14:0] pdr_in;
  logic [14:0] tm_in = '0;
  logic [14:0] tm_out;
  logic        tm_en = 1'b0;
  logic        core_wr_en = 1'b0;
  logic [14:0] core_wr_data = '0;
  logic [14:0] core_rd_data;
  logic [14:0] irq_clr = '0;
  logic [14:0] irq_flags;
  logic        edge_irq;

  int checks = 0;
  int errors = 0;

  gpio_core_ctrl #(
    .DATA_WIDTH     (15),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pdr_out     (pdr_out),
    .pdr_in      (pdr_in),
    .tm_in       (tm_in),
    .tm_out      (tm_out),
    .tm_en       (tm_en),
    .core_wr_en  (core_wr_en),
    .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data),
    .irq_clr     (irq_clr),
    .irq_flags   (irq_flags),
    .edge_irq    (edge_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (pdr_in !== 15'h0) begin errors++; $display("FAIL rst_pdr_in: got %h exp 0000", pdr_in); end
    checks++; if (tm_out !== 15'h0) begin errors++; $display("FAIL rst_tm_out: got %h exp 0000", tm_out); end
    checks++; if (core_rd_data !== 15'h0) begin errors++; $display("FAIL rst_rd: got %h exp 0000", core_rd_data); end
    checks++; if (irq_flags !== 15'h0 || edge_irq !== 1'b0) begin errors++; $display("FAIL rst_flags: got %h/%b exp 0000/0", irq_flags, edge_irq); end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_debounce_accept;
    pdr_out[3] = 1'b1;
    tick(5);
    checks++; if (core_rd_data !== 15'h0000 || irq_flags !== 15'h0000) begin errors++; $display("FAIL deb_early: got rd=%h flags=%h exp 0000/0000", core_rd_data, irq_flags); end
    tick(1);
    checks++; if (core_rd_data !== 15'h0008) begin errors++; $display("FAIL deb_rd: got %h exp 0008", core_rd_data); end
    checks++; if (irq_flags !== 15'h0008 || edge_irq !== 1'b1) begin errors++; $display("FAIL deb_flag: got %h/%b exp 0008/1", irq_flags, edge_irq); end
    tick(4);
  endtask

  task automatic test_glitch;
    irq_clr = 15'h0008;
    tick(1);
    irq_clr = '0;
    checks++; if (irq_flags !== 15'h0000 || edge_irq !== 1'b0) begin errors++; $display("FAIL clr_flag3: got %h/%b exp 0000/0", irq_flags, edge_irq); end
    // Three samples is one short of acceptance.
    pdr_out[0] = 1'b1;
    tick(3);
    pdr_out[0] = 1'b0;
    tick(8);
    checks++; if (core_rd_data !== 15'h0008 || irq_flags !== 15'h0000) begin errors++; $display("FAIL glitch3: got rd=%h flags=%h exp 0008/0000", core_rd_data, irq_flags); end
    // Four held samples reach the terminal count.
    pdr_out[0] = 1'b1;
    tick(4);
    pdr_out[0] = 1'b0;
    tick(2);
    checks++; if (core_rd_data !== 15'h0009 || irq_flags !== 15'h0001) begin errors++; $display("FAIL pulse4: got rd=%h flags=%h exp 0009/0001", core_rd_data, irq_flags); end
    tick(6);
    checks++; if (core_rd_data !== 15'h0008 || irq_flags !== 15'h0001) begin errors++; $display("FAIL fall_noflag: got rd=%h flags=%h exp 0008/0001", core_rd_data, irq_flags); end
  endtask

  task automatic test_flag_clear_race;
    irq_clr = '1;
    tick(1);
    irq_clr = '0;
    checks++; if (irq_flags !== 15'h0000 || edge_irq !== 1'b0) begin errors++; $display("FAIL clr_all: got %h/%b exp 0000/0", irq_flags, edge_irq); end
    pdr_out[5] = 1'b1;
    tick(6);
    checks++; if (irq_flags !== 15'h0020) begin errors++; $display("FAIL set5: got %h exp 0020", irq_flags); end
    irq_clr = 15'h0020;
    tick(1);
    irq_clr = '0;
    checks++; if (irq_flags !== 15'h0000) begin errors++; $display("FAIL clr5: got %h exp 0000", irq_flags); end
    pdr_out[5] = 1'b0;
    tick(7);
    checks++; if (core_rd_data !== 15'h0008 || irq_flags !== 15'h0000) begin errors++; $display("FAIL fall5: got rd=%h flags=%h exp 0008/0000", core_rd_data, irq_flags); end
    pdr_out[5] = 1'b1;
    tick(5);
    irq_clr = 15'h0020;
    tick(1);
    irq_clr = '0;
    checks++; if (irq_flags !== 15'h0020 || core_rd_data !== 15'h0028) begin errors++; $display("FAIL race5: got flags=%h rd=%h exp 0020/0028", irq_flags, core_rd_data); end
  endtask

  task automatic test_independent_bits;
    pdr_out[1] = 1'b1;
    pdr_out[2] = 1'b1;
    tick(2);
    pdr_out[2] = 1'b0;
    tick(4);
    checks++; if (core_rd_data !== 15'h002A || irq_flags !== 15'h0022) begin errors++; $display("FAIL indep: got rd=%h flags=%h exp 002a/0022", core_rd_data, irq_flags); end
  endtask

  task automatic test_output_path;
    core_wr_data = 15'h5A5A;
    core_wr_en   = 1'b1;
    tick(1);
    core_wr_en   = 1'b0;
    core_wr_data = '0;
    checks++; if (pdr_in !== 15'h5A5A || tm_out !== 15'h0000) begin errors++; $display("FAIL wr_out: got pdr_in=%h tm_out=%h exp 5a5a/0000", pdr_in, tm_out); end
  endtask

  task automatic test_mode;
    tm_in = 15'h1234;
    tm_en = 1'b1;
    tick(1);
    checks++; if (pdr_in !== 15'h5A5A) begin errors++; $display("FAIL tm_enter_early: got %h exp 5a5a", pdr_in); end
    tick(2);
    checks++; if (pdr_in !== 15'h1234 || tm_out !== 15'h002A) begin errors++; $display("FAIL tm_enter: got pdr_in=%h tm_out=%h exp 1234/002a", pdr_in, tm_out); end
    pdr_out = 15'h4101;
    tick(2);
    checks++; if (tm_out !== 15'h002A) begin errors++; $display("FAIL tm_loop_lat: got %h exp 002a", tm_out); end
    tick(1);
    checks++; if (tm_out !== 15'h4101) begin errors++; $display("FAIL tm_loop: got %h exp 4101", tm_out); end
    core_wr_data = 15'h7FFF;
    core_wr_en   = 1'b1;
    tick(1);
    core_wr_en   = 1'b0;
    checks++; if (pdr_in !== 15'h1234) begin errors++; $display("FAIL tm_wr_hidden: got %h exp 1234", pdr_in); end
    tm_in = 15'h0F0F;
    tick(1);
    checks++; if (pdr_in !== 15'h0F0F) begin errors++; $display("FAIL tm_in_reg: got %h exp 0f0f", pdr_in); end
    tick(6);
    checks++; if (core_rd_data !== 15'h4101 || irq_flags !== 15'h4123) begin errors++; $display("FAIL tm_debounce: got rd=%h flags=%h exp 4101/4123", core_rd_data, irq_flags); end
    tm_en = 1'b0;
    tick(1);
    checks++; if (pdr_in !== 15'h0F0F || tm_out !== 15'h4101) begin errors++; $display("FAIL tm_exit_early: got pdr_in=%h tm_out=%h exp 0f0f/4101", pdr_in, tm_out); end
    tick(2);
    checks++; if (pdr_in !== 15'h7FFF || tm_out !== 15'h0000) begin errors++; $display("FAIL tm_exit: got pdr_in=%h tm_out=%h exp 7fff/0000", pdr_in, tm_out); end
  endtask

  task automatic test_reset_mid;
    pdr_out = 15'h0000;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pdr_in !== 15'h0 || tm_out !== 15'h0) begin errors++; $display("FAIL rstmid_out: got pdr_in=%h tm_out=%h exp 0000/0000", pdr_in, tm_out); end
    checks++; if (core_rd_data !== 15'h0 || irq_flags !== 15'h0 || edge_irq !== 1'b0) begin errors++; $display("FAIL rstmid_state: got rd=%h flags=%h irq=%b exp 0000/0000/0", core_rd_data, irq_flags, edge_irq); end
    tick(2);
    rst = 1'b0;
    tick(8);
    checks++; if (core_rd_data !== 15'h0 || irq_flags !== 15'h0 || pdr_in !== 15'h0) begin errors++; $display("FAIL rstmid_after: got rd=%h flags=%h pdr_in=%h exp 0000/0000/0000", core_rd_data, irq_flags, pdr_in); end
  endtask

  initial begin
    test_reset;
    test_debounce_accept;
    test_glitch;
    test_flag_clear_race;
    test_independent_bits;
    test_output_path;
    test_mode;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
